// File: rtl/hazard_unit_mc_if.sv
// Signal bundle between the 5-stage pipeline datapath and the hazard unit.
// The master modport is the datapath side; the slave modport is the hazard unit.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] RsD;
    logic [REG_AW-1:0] RtD;
    logic              BranchD;
    logic [REG_AW-1:0] RsE;
    logic [REG_AW-1:0] RtE;
    logic [REG_AW-1:0] WriteRegE;
    logic [1:0]        MemtoRegE;
    logic              RegWriteE;
    logic              DivStartE;
    logic [REG_AW-1:0] WriteRegM;
    logic [1:0]        MemtoRegM;
    logic              RegWriteM;
    logic              ExceptM;
    logic [REG_AW-1:0] WriteRegW;
    logic              RegWriteW;
    logic              StatClr;

    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              FlushD;
    logic              FlushE;
    logic              FlushM;
    logic              FlushW;
    logic              ForwardAD;
    logic              ForwardBD;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              DivBusy;
    logic              DivDoneE;
    logic [CNT_W-1:0]  StallCycles;

    modport master (
        output RsD, RtD, BranchD, RsE, RtE, WriteRegE, MemtoRegE, RegWriteE,
               DivStartE, WriteRegM, MemtoRegM, RegWriteM, ExceptM,
               WriteRegW, RegWriteW, StatClr,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM, FlushW,
               ForwardAD, ForwardBD, ForwardAE, ForwardBE,
               DivBusy, DivDoneE, StallCycles
    );

    modport slave (
        input  RsD, RtD, BranchD, RsE, RtE, WriteRegE, MemtoRegE, RegWriteE,
               DivStartE, WriteRegM, MemtoRegM, RegWriteM, ExceptM,
               WriteRegW, RegWriteW, StatClr,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM, FlushW,
               ForwardAD, ForwardBD, ForwardAE, ForwardBE,
               DivBusy, DivDoneE, StallCycles
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load-use and branch
// stalls, a multi-cycle divider stall FSM, exception flush and a stall counter.
module hazard_unit_mc #(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard_unit_mc_if.slave        hif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    localparam logic [1:0] MEM_LOAD = 2'b11;
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    div_state_t        r_state;
    div_state_t        w_state_next;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_next;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic              w_rs_d_nz;
    logic              w_rt_d_nz;
    logic              w_lw_stall;
    logic              w_br_stall;
    logic              w_haz_stall;
    logic              w_div_stall;
    logic              w_stall_f;
    logic [1:0]        w_fwd_ae;
    logic [1:0]        w_fwd_be;

    // ---------------- forwarding ----------------
    assign w_rs_d_nz = (hif.RsD != '0);
    assign w_rt_d_nz = (hif.RtD != '0);

    assign hif.ForwardAD = w_rs_d_nz && (hif.RsD == hif.WriteRegM) && hif.RegWriteM;
    assign hif.ForwardBD = w_rt_d_nz && (hif.RtD == hif.WriteRegM) && hif.RegWriteM;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_fwd_ae = 2'b00;
        w_fwd_be = 2'b00;
        // M is checked last so it wins over W; register 0 is never forwarded.
        if ((hif.RsE != '0) && (hif.RsE == hif.WriteRegW) && hif.RegWriteW) w_fwd_ae = 2'b01;
        if ((hif.RsE != '0) && (hif.RsE == hif.WriteRegM) && hif.RegWriteM) w_fwd_ae = 2'b10;
        if ((hif.RtE != '0) && (hif.RtE == hif.WriteRegW) && hif.RegWriteW) w_fwd_be = 2'b01;
        if ((hif.RtE != '0) && (hif.RtE == hif.WriteRegM) && hif.RegWriteM) w_fwd_be = 2'b10;
    end

    assign hif.ForwardAE = w_fwd_ae;
    assign hif.ForwardBE = w_fwd_be;

    // ---------------- pipeline hazards ----------------
    assign w_lw_stall = (hif.MemtoRegE == MEM_LOAD) && hif.RegWriteE && (hif.WriteRegE != '0)
                     && ((hif.WriteRegE == hif.RsD) || (hif.WriteRegE == hif.RtD));

    assign w_br_stall = hif.BranchD && (
                          (hif.RegWriteE && (hif.WriteRegE != '0)
                           && ((hif.WriteRegE == hif.RsD) || (hif.WriteRegE == hif.RtD)))
                       || ((hif.MemtoRegM == MEM_LOAD) && (hif.WriteRegM != '0)
                           && ((hif.WriteRegM == hif.RsD) || (hif.WriteRegM == hif.RtD))));

    assign w_haz_stall = w_lw_stall || w_br_stall;

    // ---------------- divider stall FSM ----------------
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (hif.DivStartE) begin
                    w_state_next = S_BUSY;
                    w_cnt_next   = DIV_LOAD;
                end
            end
            S_BUSY: begin
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt == 8'd1) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // An exception in M abandons any divide, including one starting now.
        if (hif.ExceptM) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end
    end

    // The start cycle stalls combinationally, giving DIV_CYCLES stalls in total.
    assign w_div_stall = ((r_state == S_IDLE) && hif.DivStartE) || (r_state == S_BUSY);

    // ---------------- stall / flush combination ----------------
    assign w_stall_f    = (w_haz_stall || w_div_stall) && !hif.ExceptM;
    assign hif.StallF   = w_stall_f;
    assign hif.StallD   = w_stall_f;
    assign hif.StallE   = w_div_stall && !hif.ExceptM;
    // A divide holds E in place, so no bubble goes into E while it runs.
    assign hif.FlushE   = (w_haz_stall && !w_div_stall) || hif.ExceptM;
    assign hif.FlushM   = w_div_stall || hif.ExceptM;
    assign hif.FlushD   = hif.ExceptM;
    assign hif.FlushW   = hif.ExceptM;
    assign hif.DivBusy  = (r_state == S_BUSY);
    assign hif.DivDoneE = (r_state == S_DONE) && !hif.ExceptM;

    // ---------------- stall-cycle counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (hif.StatClr) begin
            r_stall_cycles <= '0;
        end else if (w_stall_f && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign hif.StallCycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc with a short divide (4 cycles)
// and a 4-bit stall counter so saturation is reachable quickly.
module tb_hazard_unit_mc;

    localparam int REG_AW     = 5;
    localparam int DIV_CYCLES = 4;
    localparam int CNT_W      = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

    hazard_unit_mc #(
        .REG_AW    (REG_AW),
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        hif.RsD = '0;       hif.RtD = '0;       hif.BranchD = 1'b0;
        hif.RsE = '0;       hif.RtE = '0;       hif.WriteRegE = '0;
        hif.MemtoRegE = '0; hif.RegWriteE = 1'b0; hif.DivStartE = 1'b0;
        hif.WriteRegM = '0; hif.MemtoRegM = '0; hif.RegWriteM = 1'b0;
        hif.ExceptM = 1'b0; hif.WriteRegW = '0; hif.RegWriteW = 1'b0;
        hif.StatClr = 1'b0;
    endtask

    task automatic set_load_use();
        hif.MemtoRegE = 2'b11; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd8; hif.RsD = 5'd8;
    endtask

    initial begin
        logic seen_done;
        n_checks = 0;
        n_errors = 0;

        // ---- reset: all outputs low while held and after release ----
        rst = 1'b1;
        clr_in();
        #2;
        check("rst_stalls", {31'd0, hif.StallF | hif.StallD | hif.StallE}, 32'd0);
        check("rst_flushes", {28'd0, hif.FlushD, hif.FlushE, hif.FlushM, hif.FlushW}, 32'd0);
        check("rst_fwd", {26'd0, hif.ForwardAD, hif.ForwardBD, hif.ForwardAE, hif.ForwardBE}, 32'd0);
        check("rst_div", {30'd0, hif.DivBusy, hif.DivDoneE}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_cnt", 32'(hif.StallCycles), 32'd0);
        tick();
        check("idle_stallf", 32'(hif.StallF), 32'd0);

        // ---- forwarding ----
        hif.RsE = 5'd3; hif.RtE = 5'd3; hif.WriteRegM = 5'd3; hif.RegWriteM = 1'b1;
        hif.WriteRegW = 5'd3; hif.RegWriteW = 1'b1; hif.RsD = 5'd3;
        #1;
        check("fwd_ae_m_prio", 32'(hif.ForwardAE), 32'd2);
        check("fwd_be_m_prio", 32'(hif.ForwardBE), 32'd2);
        check("fwd_ad_m", 32'(hif.ForwardAD), 32'd1);
        hif.RegWriteM = 1'b0;
        #1;
        check("fwd_ae_w", 32'(hif.ForwardAE), 32'd1);
        check("fwd_ad_nowe", 32'(hif.ForwardAD), 32'd0);
        hif.RegWriteM = 1'b1; hif.RsE = 5'd0; hif.RsD = 5'd0; hif.WriteRegM = 5'd0;
        #1;
        check("fwd_ae_r0", 32'(hif.ForwardAE), 32'd0);
        check("fwd_ad_r0", 32'(hif.ForwardAD), 32'd0);
        check("fwd_be_r3_w", 32'(hif.ForwardBE), 32'd1);
        clr_in();

        // ---- load-use stall ----
        set_load_use();
        #1;
        check("lw_stallf", 32'(hif.StallF), 32'd1);
        check("lw_stalld", 32'(hif.StallD), 32'd1);
        check("lw_flushe", 32'(hif.FlushE), 32'd1);
        check("lw_stalle", 32'(hif.StallE), 32'd0);
        check("lw_flushm", 32'(hif.FlushM), 32'd0);
        tick();
        check("lw_cnt", 32'(hif.StallCycles), 32'd1);
        hif.WriteRegE = 5'd0; hif.RsD = 5'd0;
        #1;
        check("lw_r0_nostall", 32'(hif.StallF), 32'd0);
        clr_in();

        // ---- divide: 4 stall cycles, DONE pulse after ----
        hif.DivStartE = 1'b1;
        #1;
        check("div0_stall", {29'd0, hif.StallF, hif.StallD, hif.StallE}, 32'd7);
        check("div0_flushm", 32'(hif.FlushM), 32'd1);
        check("div0_flushe", 32'(hif.FlushE), 32'd0);
        check("div0_busy", 32'(hif.DivBusy), 32'd0);
        for (int k = 1; k < DIV_CYCLES; k++) begin
            tick();
            check("divk_stall", {28'd0, hif.StallF, hif.StallD, hif.StallE, hif.FlushM}, 32'hF);
            check("divk_busy_done", {30'd0, hif.DivBusy, hif.DivDoneE}, 32'd2);
        end
        tick();
        check("div_done", 32'(hif.DivDoneE), 32'd1);
        check("div_done_stall", {28'd0, hif.StallF, hif.StallD, hif.StallE, hif.FlushM}, 32'd0);
        check("div_done_busy", 32'(hif.DivBusy), 32'd0);
        check("div_cnt", 32'(hif.StallCycles), 32'd5);
        hif.DivStartE = 1'b0;
        tick();
        check("div_after", {30'd0, hif.DivBusy, hif.DivDoneE}, 32'd0);

        // ---- exception on 2nd BUSY cycle ----
        hif.DivStartE = 1'b1;
        tick();
        tick();
        hif.ExceptM = 1'b1;
        #1;
        check("exc_stalls", {29'd0, hif.StallF, hif.StallD, hif.StallE}, 32'd0);
        check("exc_flushes", {28'd0, hif.FlushD, hif.FlushE, hif.FlushM, hif.FlushW}, 32'hF);
        check("exc_donee", 32'(hif.DivDoneE), 32'd0);
        tick();
        hif.ExceptM = 1'b0; hif.DivStartE = 1'b0;
        #1;
        check("exc_idle", 32'(hif.DivBusy), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen_done |= hif.DivDoneE;
            tick();
        end
        check("exc_no_done", 32'(seen_done), 32'd0);
        check("exc_cnt", 32'(hif.StallCycles), 32'd7);

        // ---- exception coincident with divide start ----
        hif.DivStartE = 1'b1; hif.ExceptM = 1'b1;
        #1;
        check("excst_stall", {30'd0, hif.StallF, hif.StallE}, 32'd0);
        check("excst_flush", {30'd0, hif.FlushE, hif.FlushM}, 32'd3);
        tick();
        clr_in();
        #1;
        check("excst_nobusy", 32'(hif.DivBusy), 32'd0);
        check("excst_cnt", 32'(hif.StallCycles), 32'd7);

        // ---- branch stalls ----
        hif.BranchD = 1'b1; hif.RsD = 5'd5; hif.MemtoRegM = 2'b11;
        hif.WriteRegM = 5'd5; hif.RegWriteM = 1'b1;
        #1;
        check("br_m_stalld", 32'(hif.StallD), 32'd1);
        check("br_m_flushe", 32'(hif.FlushE), 32'd1);
        check("br_m_fwdad", 32'(hif.ForwardAD), 32'd1);
        hif.MemtoRegM = 2'b00;
        #1;
        check("br_alu_m_nostall", 32'(hif.StallD), 32'd0);
        check("br_alu_m_fwdad", 32'(hif.ForwardAD), 32'd1);
        hif.RtD = 5'd6; hif.WriteRegE = 5'd6; hif.RegWriteE = 1'b1;
        #1;
        check("br_e_stalld", 32'(hif.StallD), 32'd1);
        hif.BranchD = 1'b0;
        #1;
        check("nobr_e_nostall", 32'(hif.StallD), 32'd0);
        clr_in();

        // ---- counter saturation and clear ----
        set_load_use();
        for (int k = 0; k < 7; k++) tick();
        check("sat_14", 32'(hif.StallCycles), 32'd14);
        tick();
        check("sat_15", 32'(hif.StallCycles), 32'd15);
        for (int k = 0; k < 5; k++) tick();
        check("sat_hold", 32'(hif.StallCycles), 32'd15);
        hif.StatClr = 1'b1;
        #1;
        check("clr_pre_edge", 32'(hif.StallCycles), 32'd15);
        tick();
        check("clr_prio", 32'(hif.StallCycles), 32'd0);
        hif.StatClr = 1'b0;
        tick();
        check("clr_then_inc", 32'(hif.StallCycles), 32'd1);
        clr_in();

        // ---- asynchronous reset in the middle of a divide ----
        hif.DivStartE = 1'b1;
        tick();
        check("rstdiv_busy", 32'(hif.DivBusy), 32'd1);
        #2;
        rst = 1'b1; hif.DivStartE = 1'b0;
        #1;
        check("rstdiv_stalls", {29'd0, hif.StallF, hif.StallE, hif.FlushM}, 32'd0);
        check("rstdiv_idle", 32'(hif.DivBusy), 32'd0);
        check("rstdiv_cnt", 32'(hif.StallCycles), 32'd0);
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen_done |= hif.DivDoneE | hif.DivBusy;
        end
        check("rstdiv_no_done", 32'(seen_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
